hilo_mult_sequencer: RTL and testbench

Multi-cycle sequencer for the HI/LO multiply path of the EX stage. It decodes the 6-bit ALUControl code for MULT, MULTU, MADD, MSUB, MTHI, MTLO, MFHI and MFLO, and runs an iterative shift-add multiplier over W cycles. It owns the HI/LO registers and raises Stall to the hazard unit while a HI/LO-dependent instruction must wait for a multiply in flight.

---
 rtl/hilo_mult_sequencer.sv | 148 ++++++++++++++
 tb/tb_hilo_mult_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_sequencer.sv
// HI/LO multiply sequencer for the EX stage.
// Decodes the HI/LO ALUControl codes and runs a W-cycle shift-add multiplier.
// Owns HI/LO and stalls HI/LO-dependent instructions while a multiply is in flight.
module hilo_mult_sequencer #(
  parameter int unsigned W = 32
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [5:0]   ALUControl,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         Stall,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [5:0] OpMult  = 6'b000011;
  localparam logic [5:0] OpMultu = 6'b000100;
  localparam logic [5:0] OpMadd  = 6'b010100;
  localparam logic [5:0] OpMsub  = 6'b010101;
  localparam logic [5:0] OpMfhi  = 6'b010111;
  localparam logic [5:0] OpMflo  = 6'b011000;
  localparam logic [5:0] OpMthi  = 6'b011001;
  localparam logic [5:0] OpMtlo  = 6'b011010;

  typedef enum logic [1:0] {StIdle, StCalc, StAcc} state_e;

  state_e          state_q, state_d;
  logic [5:0]      op_q;
  logic [W-1:0]    mcand_q, mplier_q;
  logic            neg_q;
  logic [CW-1:0]   count_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    hi_q, lo_q;
  logic            done_q;

  logic            is_mul, is_mt, is_mf, request;
  logic [W-1:0]    a_abs, b_abs;
  logic [2*W-1:0]  product, hilo_next;

  // Decode the incoming code into request classes.
  always_comb begin
    is_mul  = (ALUControl == OpMult) || (ALUControl == OpMultu) ||
              (ALUControl == OpMadd) || (ALUControl == OpMsub);
    is_mt   = (ALUControl == OpMthi) || (ALUControl == OpMtlo);
    is_mf   = (ALUControl == OpMfhi) || (ALUControl == OpMflo);
    request = Start && (is_mul || is_mt || is_mf);
    // Negating the most negative value wraps back to itself, which is the
    // correct unsigned magnitude 2^(W-1).
    a_abs   = A[W-1] ? (~A + 1'b1) : A;
    b_abs   = B[W-1] ? (~B + 1'b1) : B;
  end

  // Apply the sign and fold the product into HI/LO for the latched op.
  always_comb begin
    product = neg_q ? (~acc_q + 1'b1) : acc_q;
    case (op_q)
      OpMadd:  hilo_next = {hi_q, lo_q} + product;
      OpMsub:  hilo_next = {hi_q, lo_q} - product;
      default: hilo_next = product;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (Start && is_mul) state_d = StCalc;
      StCalc: if (count_q == CW'(W - 1)) state_d = StAcc;
      StAcc:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state; stalls only real requests.
  always_comb begin
    Busy  = (state_q != StIdle);
    Stall = Busy && request;
    Done  = done_q;
    HI    = hi_q;
    LO    = lo_q;
  end

  // Datapath: operand latch, shift-add iteration and HI/LO update.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Start && is_mul) begin
            op_q    <= ALUControl;
            count_q <= '0;
            acc_q   <= '0;
            if (ALUControl == OpMultu) begin
              mcand_q  <= A;
              mplier_q <= B;
              neg_q    <= 1'b0;
            end else begin
              mcand_q  <= a_abs;
              mplier_q <= b_abs;
              neg_q    <= A[W-1] ^ B[W-1];
            end
          end else if (Start && (ALUControl == OpMthi)) begin
            hi_q <= A;
          end else if (Start && (ALUControl == OpMtlo)) begin
            lo_q <= A;
          end
        end
        StCalc: begin
          if (mplier_q[count_q]) begin
            acc_q <= acc_q + ({{W{1'b0}}, mcand_q} << count_q);
          end
          count_q <= count_q + CW'(1);
        end
        StAcc: begin
          {hi_q, lo_q} <= hilo_next;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Self-checking bench for hilo_mult_sequencer: directed steps plus random
// multiply/move ops checked against an arithmetic HI/LO model.
module tb_hilo_mult_sequencer;

  localparam int unsigned W = 32;

  localparam logic [5:0] OpMult  = 6'b000011;
  localparam logic [5:0] OpMultu = 6'b000100;
  localparam logic [5:0] OpMadd  = 6'b010100;
  localparam logic [5:0] OpMsub  = 6'b010101;
  localparam logic [5:0] OpMflo  = 6'b011000;
  localparam logic [5:0] OpMthi  = 6'b011001;
  localparam logic [5:0] OpMtlo  = 6'b011010;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [5:0]    ALUControl;
  logic [W-1:0]  A, B;
  logic          Stall, Busy, Done;
  logic [W-1:0]  HI, LO;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [63:0]   m_hilo;

  hilo_mult_sequencer #(.W(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Stall      (Stall),
    .Busy       (Busy),
    .Done       (Done),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-width product as plain signed or unsigned arithmetic.
  function automatic logic [63:0] ref_prod(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    if (op == OpMultu) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic model_mul(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = ref_prod(op, a, b);
    if (op == OpMadd) m_hilo = m_hilo + p;
    else if (op == OpMsub) m_hilo = m_hilo - p;
    else m_hilo = p;
  endtask

  // Issue one multiply-class op and follow it through to Done.
  task automatic do_mul(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned bad_busy;
    @(posedge Clk); #1;
    Start = 1'b1; ALUControl = op; A = a; B = b;
    #1 check("stall_idle", {63'b0, Stall}, 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0; A = $urandom; B = $urandom;
    bad_busy = 0;
    for (int k = 0; k <= W; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      if ({Busy, Done} !== 2'b10) bad_busy++;
    end
    check("busy_window", 64'(bad_busy), 64'd0);
    model_mul(op, a, b);
    @(posedge Clk); #1;
    check("done_cycle", {62'b0, Busy, Done}, 64'b01);
    check("hilo_result", {HI, LO}, m_hilo);
    @(posedge Clk); #1;
    check("done_single", {63'b0, Done}, 64'd0);
  endtask

  task automatic do_mt(input logic [5:0] op, input logic [31:0] a);
    @(posedge Clk); #1;
    Start = 1'b1; ALUControl = op; A = a;
    #1 check("stall_mt", {63'b0, Stall}, 64'd0);
    @(posedge Clk); #1;
    Start = 1'b0;
    if (op == OpMthi) m_hilo[63:32] = a;
    else m_hilo[31:0] = a;
    check("hilo_mt", {HI, LO}, m_hilo);
  endtask

  initial begin
    logic        seen;
    logic [5:0]  ops [6];
    logic [5:0]  op;
    logic [31:0] ra, rb;
    ops[0] = OpMult; ops[1] = OpMultu; ops[2] = OpMadd;
    ops[3] = OpMsub; ops[4] = OpMthi;  ops[5] = OpMtlo;

    // Reset with a request presented: nothing may stall or move.
    Rst = 1'b0; Start = 1'b1; ALUControl = OpMult; A = 32'd5; B = 32'd7;
    m_hilo = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_stall", {63'b0, Stall}, 64'd0);
    check("rst_state", {62'b0, Busy, Done}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    Start = 1'b0; Rst = 1'b1;
    @(posedge Clk); #1;
    check("post_rst", {HI, LO, 30'b0, Busy, Done}, 96'd0);

    // Directed multiplies.
    do_mul(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    do_mul(OpMult, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_mul(OpMult, 32'h8000_0000, 32'h8000_0000);
    check("mult_minmin", {HI, LO}, 64'h4000_0000_0000_0000);

    // Accumulate sequence.
    do_mt(OpMthi, 32'd0);
    do_mt(OpMtlo, 32'd10);
    do_mul(OpMadd, 32'hFFFF_FFFF, 32'd5);
    check("madd", {HI, LO}, 64'h0000_0000_0000_0005);
    do_mul(OpMsub, 32'd2, 32'd3);
    check("msub", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Interlock: MFLO held from cycle 5 stalls until the Done cycle.
    @(posedge Clk); #1;
    Start = 1'b1; ALUControl = OpMult; A = 32'd7; B = 32'd6;
    @(posedge Clk); #1;
    Start = 1'b0;
    model_mul(OpMult, 32'd7, 32'd6);
    seen = 1'b0;
    for (int c = 1; c <= W; c++) begin
      @(posedge Clk); #1;
      if (c == 2) begin
        Start = 1'b1; ALUControl = 6'b000000;
        #1 check("stall_add", {63'b0, Stall}, 64'd0);
      end else if (c >= 4) begin
        Start = 1'b1; ALUControl = OpMflo;
        #1 if (Stall !== 1'b1) seen = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    check("stall_held", {63'b0, seen}, 64'd0);
    @(posedge Clk); #1;
    check("stall_done", {62'b0, Stall, Done}, 64'b01);
    check("lo_42", {HI, LO}, m_hilo);
    @(posedge Clk); #1;
    Start = 1'b0;

    // Reset mid-CALC discards the op.
    do_mt(OpMtlo, 32'd9);
    @(posedge Clk); #1;
    Start = 1'b1; ALUControl = OpMult; A = 32'd3; B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    check("midrst", {HI, LO, 30'b0, Busy, Done}, 96'd0);
    m_hilo = '0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < W + 3; c++) begin
      @(posedge Clk); #1;
      if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
    end
    check("no_done_after_rst", {63'b0, seen}, 64'd0);
    do_mul(OpMultu, 32'd2, 32'd2);
    check("lo_4", {HI, LO}, 64'd4);

    // Random ops against the model.
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 5)];
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      if (op == OpMthi || op == OpMtlo) do_mt(op, ra);
      else do_mul(op, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
